// File: rtl/convolve_kernel_ctrl_if.sv
// Host/stream/kernel bundle between the kernel configuration controller and its environment.
// The master side is the host plus pixel stream; the slave side is the controller.
interface convolve_kernel_ctrl_if #(
  parameter int KRNL_SZ = 5
);
  localparam int N = KRNL_SZ * KRNL_SZ;

  logic           wr_en;
  logic [7:0]     wr_addr;
  logic [7:0]     wr_data;
  logic           commit;
  logic [9:0]     in_x;
  logic [9:0]     in_y;
  logic           is_in_val;
  logic [N*8-1:0] kernel;
  logic           busy;
  logic           err_overflow;
  logic           swap_pulse;
  logic [7:0]     frame_cnt;

  modport master (
    output wr_en, wr_addr, wr_data, commit, in_x, in_y, is_in_val,
    input  kernel, busy, err_overflow, swap_pulse, frame_cnt
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, commit, in_x, in_y, is_in_val,
    output kernel, busy, err_overflow, swap_pulse, frame_cnt
  );
endinterface

// File: rtl/convolve_kernel_ctrl.sv
// Shadow-bank kernel controller: validates a committed kernel against the convolver's
// positive/negative sum limits and swaps it into the active bus only at a frame start.
module convolve_kernel_ctrl #(
  parameter int KRNL_SZ = 5
) (
  input logic                   clk,
  input logic                   reset,
  convolve_kernel_ctrl_if.slave bus
);
  localparam int N     = KRNL_SZ * KRNL_SZ;
  localparam int IDX_W = 9;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_PENDING
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_shadow [N];
  logic [7:0]       r_kernel [N];
  logic [IDX_W-1:0] r_idx;
  logic [15:0]      r_pos_sum;
  logic [15:0]      r_neg_sum;
  logic             r_busy;
  logic             r_err_overflow;
  logic             r_swap_pulse;
  logic [7:0]       r_frame_cnt;

  logic             w_fs;
  logic [7:0]       w_coef;
  logic [7:0]       w_mag;
  logic             w_check_done;
  logic             w_pass;
  logic [N*8-1:0]   w_kernel_flat;

  assign w_fs         = bus.is_in_val && (bus.in_x == 10'd0) && (bus.in_y == 10'd0);
  assign w_check_done = (r_idx == IDX_W'(N));
  assign w_pass       = (r_pos_sum <= 16'd127) && (r_neg_sum <= 16'd127);
  assign w_mag        = ~w_coef + 8'd1;

  always_comb begin
    w_coef = 8'h00;
    for (int i = 0; i < N; i++) begin
      if (r_idx == IDX_W'(i)) w_coef = r_shadow[i];
    end
  end

  // Coefficient 0 sits in the most significant byte of the flattened bus.
  always_comb begin
    w_kernel_flat = '0;
    for (int i = 0; i < N; i++) begin
      w_kernel_flat[(N-1-i)*8 +: 8] = r_kernel[i];
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (bus.commit) w_next = S_CHECK;
      S_CHECK:   if (w_check_done) w_next = w_pass ? S_PENDING : S_IDLE;
      S_PENDING: if (w_fs) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        r_shadow[i] <= (i == N/2) ? 8'h10 : 8'h00;
        r_kernel[i] <= (i == N/2) ? 8'h10 : 8'h00;
      end
      r_idx          <= '0;
      r_pos_sum      <= '0;
      r_neg_sum      <= '0;
      r_busy         <= 1'b0;
      r_err_overflow <= 1'b0;
      r_swap_pulse   <= 1'b0;
      r_frame_cnt    <= 8'd0;
    end else begin
      r_swap_pulse <= 1'b0;
      r_busy       <= (w_next != S_IDLE);
      if (w_fs) r_frame_cnt <= r_frame_cnt + 8'd1;
      case (r_state)
        S_IDLE: begin
          // Out-of-range addresses match no entry and are dropped.
          if (bus.wr_en) begin
            for (int i = 0; i < N; i++) begin
              if (bus.wr_addr == 8'(i)) r_shadow[i] <= bus.wr_data;
            end
          end
          if (bus.commit) begin
            r_err_overflow <= 1'b0;
            r_idx          <= '0;
            r_pos_sum      <= '0;
            r_neg_sum      <= '0;
          end
        end
        S_CHECK: begin
          if (!w_check_done) begin
            r_idx <= r_idx + IDX_W'(1);
            if (w_coef[7]) r_neg_sum <= r_neg_sum + {8'd0, w_mag};
            else           r_pos_sum <= r_pos_sum + {8'd0, w_coef};
          end else if (!w_pass) begin
            r_err_overflow <= 1'b1;
          end
        end
        S_PENDING: begin
          if (w_fs) begin
            r_kernel     <= r_shadow;
            r_swap_pulse <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.kernel       = w_kernel_flat;
  assign bus.busy         = r_busy;
  assign bus.err_overflow = r_err_overflow;
  assign bus.swap_pulse   = r_swap_pulse;
  assign bus.frame_cnt    = r_frame_cnt;
endmodule

// File: tb/tb_convolve_kernel_ctrl.sv
// Directed bench for convolve_kernel_ctrl: hand-built kernels, limit boundaries,
// frame-aligned swap timing, reset in PENDING and frame counter wrap.
module tb_convolve_kernel_ctrl;
  localparam int KRNL_SZ = 5;
  localparam int N       = KRNL_SZ * KRNL_SZ;

  logic clk = 1'b0;
  logic reset = 1'b1;

  convolve_kernel_ctrl_if #(.KRNL_SZ(KRNL_SZ)) cbus ();

  convolve_kernel_ctrl #(.KRNL_SZ(KRNL_SZ)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (cbus)
  );

  always #5 clk = ~clk;

  int         nAsserts = 0;
  int         nFails = 0;
  logic [7:0] expFrame = 8'd0;
  logic [7:0] kv [N];
  logic [N*8-1:0] expKernel;
  logic [N*8-1:0] identK;

  function automatic logic [N*8-1:0] packKernel();
    logic [N*8-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[(N-1-i)*8 +: 8] = kv[i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One pixel strobe (or idle beat when val=0) at the given coordinates.
  task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y, input logic val);
    cbus.is_in_val = val;
    cbus.in_x      = x;
    cbus.in_y      = y;
    tick();
    cbus.is_in_val = 1'b0;
    if (val && x == 10'd0 && y == 10'd0) expFrame = expFrame + 8'd1;
  endtask

  // Writes kv[] into the shadow bank; optionally raises commit with the last write.
  task automatic loadKernel(input logic commitLast);
    for (int i = 0; i < N; i++) begin
      cbus.wr_en   = 1'b1;
      cbus.wr_addr = 8'(i);
      cbus.wr_data = kv[i];
      cbus.commit  = commitLast && (i == N-1);
      tick();
    end
    cbus.wr_en  = 1'b0;
    cbus.commit = 1'b0;
  endtask

  task automatic doCommit();
    cbus.commit = 1'b1;
    tick();
    cbus.commit = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    cbus.wr_en = 1'b0; cbus.wr_addr = 8'd0; cbus.wr_data = 8'd0; cbus.commit = 1'b0;
    cbus.in_x = 10'd5; cbus.in_y = 10'd5; cbus.is_in_val = 1'b0;
    for (int i = 0; i < N; i++) kv[i] = (i == 12) ? 8'h10 : 8'h00;
    identK = packKernel();
    ticks(2);
    reset = 1'b0;

    checkOutput("rst_kernel", cbus.kernel, identK);
    checkOutput("rst_busy", cbus.busy, 0);
    checkOutput("rst_err", cbus.err_overflow, 0);
    checkOutput("rst_swap", cbus.swap_pulse, 0);
    checkOutput("rst_frame", cbus.frame_cnt, 0);

    // Box blur, pos_sum = 40: accepted, swapped only at (0,0).
    for (int i = 0; i < N; i++) kv[i] = (i == 12) ? 8'h10 : 8'h01;
    expKernel = packKernel();
    loadKernel(1'b0);
    checkOutput("box_pre_kernel", cbus.kernel, identK);
    doCommit();
    checkOutput("box_busy_t1", cbus.busy, 1);
    for (int k = 1; k <= 26; k++) begin
      tick();
      checkOutput("box_busy_run", cbus.busy, 1);
    end
    checkOutput("box_err", cbus.err_overflow, 0);
    checkOutput("box_no_early_swap", cbus.swap_pulse, 0);
    applyStimulus(10'd3, 10'd0, 1'b1);
    checkOutput("box_nonfs_swap", cbus.swap_pulse, 0);
    checkOutput("box_nonfs_kernel", cbus.kernel, identK);
    applyStimulus(10'd0, 10'd0, 1'b1);
    checkOutput("box_swap", cbus.swap_pulse, 1);
    checkOutput("box_kernel", cbus.kernel, expKernel);
    checkOutput("box_busy_done", cbus.busy, 0);
    checkOutput("box_frame", cbus.frame_cnt, expFrame);
    tick();
    checkOutput("box_swap_end", cbus.swap_pulse, 0);

    // All 8'h08, pos_sum = 200: rejected, kernel kept, no swap.
    for (int i = 0; i < N; i++) kv[i] = 8'h08;
    loadKernel(1'b0);
    doCommit();
    ticks(25);
    checkOutput("pos_ovf_busy_t25", cbus.busy, 1);
    checkOutput("pos_ovf_err_t25", cbus.err_overflow, 0);
    tick();
    checkOutput("pos_ovf_busy", cbus.busy, 0);
    checkOutput("pos_ovf_err", cbus.err_overflow, 1);
    checkOutput("pos_ovf_kernel", cbus.kernel, expKernel);
    applyStimulus(10'd0, 10'd0, 1'b1);
    checkOutput("pos_ovf_swap", cbus.swap_pulse, 0);
    checkOutput("pos_ovf_kernel_fs", cbus.kernel, expKernel);
    checkOutput("pos_ovf_frame", cbus.frame_cnt, expFrame);

    // 16 x -0.5, neg_sum = 128: rejected.
    for (int i = 0; i < N; i++) kv[i] = (i < 16) ? 8'hF8 : 8'h00;
    loadKernel(1'b0);
    doCommit();
    checkOutput("neg_ovf_err_cleared", cbus.err_overflow, 0);
    ticks(26);
    checkOutput("neg_ovf_err", cbus.err_overflow, 1);
    checkOutput("neg_ovf_busy", cbus.busy, 0);

    // 15 x -0.5 plus 120 positive: accepted; writes and commit in PENDING ignored.
    for (int i = 0; i < N; i++) kv[i] = (i < 15) ? 8'hF8 : ((i == 15) ? 8'h78 : 8'h00);
    expKernel = packKernel();
    loadKernel(1'b0);
    doCommit();
    checkOutput("neg_ok_err_cleared", cbus.err_overflow, 0);
    ticks(26);
    checkOutput("neg_ok_busy", cbus.busy, 1);
    checkOutput("neg_ok_err", cbus.err_overflow, 0);
    cbus.wr_en = 1'b1; cbus.wr_addr = 8'd0; cbus.wr_data = 8'h55; cbus.commit = 1'b1;
    tick();
    cbus.wr_en = 1'b0; cbus.commit = 1'b0;
    checkOutput("pend_busy", cbus.busy, 1);
    applyStimulus(10'd0, 10'd0, 1'b1);
    checkOutput("pend_swap", cbus.swap_pulse, 1);
    checkOutput("pend_kernel_frozen", cbus.kernel, expKernel);
    tick();
    checkOutput("pend_busy_after", cbus.busy, 0);
    applyStimulus(10'd0, 10'd0, 1'b1);
    checkOutput("pend_single_swap", cbus.swap_pulse, 0);
    checkOutput("pend_frame", cbus.frame_cnt, expFrame);

    // Write coinciding with commit is included; FS during CHECK does not swap.
    for (int i = 0; i < N; i++) kv[i] = 8'h00;
    kv[0] = 8'h01; kv[12] = 8'h20; kv[24] = 8'h03;
    expKernel = packKernel();
    loadKernel(1'b1);
    checkOutput("chk_busy", cbus.busy, 1);
    ticks(5);
    applyStimulus(10'd0, 10'd0, 1'b1);
    checkOutput("chk_fs_no_swap", cbus.swap_pulse, 0);
    checkOutput("chk_fs_frame", cbus.frame_cnt, expFrame);
    ticks(20);
    checkOutput("chk_pending_busy", cbus.busy, 1);
    checkOutput("chk_pending_err", cbus.err_overflow, 0);
    applyStimulus(10'd0, 10'd0, 1'b1);
    checkOutput("chk_next_fs_swap", cbus.swap_pulse, 1);
    checkOutput("chk_kernel", cbus.kernel, expKernel);

    // Reset while PENDING drops the commit and restores identity.
    for (int i = 0; i < N; i++) kv[i] = (i == 12) ? 8'h10 : 8'h00;
    kv[0] = 8'h02;
    loadKernel(1'b1);
    ticks(26);
    checkOutput("rstp_busy", cbus.busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expFrame = 8'd0;
    checkOutput("rstp_busy_clr", cbus.busy, 0);
    checkOutput("rstp_kernel", cbus.kernel, identK);
    checkOutput("rstp_frame", cbus.frame_cnt, 0);
    applyStimulus(10'd0, 10'd0, 1'b1);
    checkOutput("rstp_no_swap", cbus.swap_pulse, 0);
    checkOutput("rstp_kernel_fs", cbus.kernel, identK);
    checkOutput("rstp_frame_fs", cbus.frame_cnt, expFrame);

    // Shadow was also reset; out-of-range writes are dropped.
    cbus.wr_en = 1'b1; cbus.wr_addr = 8'd25; cbus.wr_data = 8'h7F;
    tick();
    cbus.wr_addr = 8'd255;
    tick();
    cbus.wr_en = 1'b0;
    doCommit();
    ticks(26);
    checkOutput("shadow_rst_busy", cbus.busy, 1);
    applyStimulus(10'd0, 10'd0, 1'b1);
    checkOutput("shadow_rst_swap", cbus.swap_pulse, 1);
    checkOutput("shadow_rst_kernel", cbus.kernel, identK);

    // (0,0) without strobe is not a frame start; 256 frame starts wrap the count.
    applyStimulus(10'd0, 10'd0, 1'b0);
    checkOutput("frame_nostrobe", cbus.frame_cnt, expFrame);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 255; i++) applyStimulus(10'd0, 10'd0, 1'b1);
    checkOutput("frame_255", cbus.frame_cnt, 8'd255);
    applyStimulus(10'd0, 10'd0, 1'b1);
    checkOutput("frame_wrap", cbus.frame_cnt, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end
endmodule

// File: doc/convolve_kernel_ctrl.md
# convolve_kernel_ctrl

Run-time kernel configuration controller for the streaming `convolve` engine. The host writes coefficients into a shadow bank and requests a commit. The block checks the shadow kernel against the convolver's overflow limits. It then swaps the shadow bank into the active `kernel` bus only at an input frame boundary, so a frame is never convolved with a mix of two kernels. It sits beside `convolve`, monitors the same pixel stream, and drives its `kernel` input.

## Interface
- `KRNL_SZ`, 5, kernel edge length; N = KRNL_SZ*KRNL_SZ coefficients, N ≤ 256
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `wr_en`  in  1  write one shadow coefficient this cycle
- `wr_addr`  in  8  coefficient index N' = KRNL_SZ*i + j; writes with N' ≥ N are ignored
- `wr_data`  in  8  signed 4.4 coefficient
- `commit`  in  1  request validation and a frame-aligned swap
- `in_x`, `in_y`  in  10 each  pixel coordinates of the stream feeding `convolve`
- `is_in_val`  in  1  pixel strobe of that stream
- `kernel`  out  N*8  active kernel; coefficient N' occupies bits [(N−N')*8−1 : (N−N'−1)*8]
- `busy`  out  1  commit in progress (CHECK or PENDING)
- `err_overflow`  out  1  last commit rejected by limit check
- `swap_pulse`  out  1  one-cycle strobe on the cycle `kernel` takes the new value
- `frame_cnt`  out  8  count of input frame starts, wraps

## Operation
- Reset values:
  - `kernel` and shadow bank = identity: centre index N/2 = 8'h10 (1.0), all others 0
  - `busy`, `err_overflow` and `swap_pulse` = 0
  - `frame_cnt` = 0
  - FSM = IDLE
- Frame start (FS): `is_in_val` & `in_x`==0 & `in_y`==0, sampled at a clock edge.
- `frame_cnt` increments on every FS in every state; it wraps from 255 to 0.
- IDLE:
  - `wr_en` writes `wr_data` into shadow[`wr_addr`].
  - `commit` clears `err_overflow`, clears the index/accumulators and moves to CHECK.
  - If `wr_en` and `commit` occur in the same cycle, the write lands first and is included in the check.
- CHECK, one coefficient per cycle for index 0..N−1:
  - Positive values are added to `pos_sum` and negative magnitudes to `neg_sum`.
  - Both accumulators are 16-bit unsigned. No overflow is possible: 25·128 < 2^16.
  - After index N−1 is accumulated:
    - pass if `pos_sum` ≤ 127 and `neg_sum` ≤ 127 → PENDING
    - otherwise `err_overflow`←1 → IDLE, and `kernel` is unchanged
- PENDING: waits for the next FS. On that edge: `kernel`←shadow, `swap_pulse`←1 for one cycle, → IDLE.
- `wr_en` and `commit` are ignored while `busy`=1; the shadow bank is frozen during CHECK and PENDING.
- An FS occurring during CHECK does not swap. The swap waits for the first FS seen in PENDING.
- `reset` in any state returns to IDLE with the reset values above; any pending commit is dropped.

## Timing
- `commit` sampled at edge t → `busy`=1 from t+1.
- CHECK occupies edges t+1..t+N. The verdict takes effect at edge t+N+1: state, `err_overflow` and `busy` (fail: `busy`=0).
- PENDING with FS sampled at edge f → `kernel` = new value and `swap_pulse`=1 and `busy`=0, all visible after f. `swap_pulse` returns to 0 after f+1.
- Swap latency therefore = N+1 cycles + wait for the next FS.
- `frame_cnt` updates at the same edge as FS; on a swap it changes together with `kernel`.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset → `kernel` has 8'h10 at index 12 (KRNL_SZ=5) and zeros elsewhere; `busy`=0, `frame_cnt`=0.
- Write a 5×5 box blur:
  - 24 × 8'h01 and centre 8'h10, `pos_sum`=40; commit.
  - Required: `busy`=1 for 26 cycles, then PENDING.
  - Stream to (0,0) → `swap_pulse` for one cycle and `kernel` updated.
- Write all 25 as 8'h08 (`pos_sum`=200), commit → after 26 cycles `err_overflow`=1, `busy`=0, `kernel` unchanged, and no swap at the next FS.
- Negative limit: 16 × 8'hF8 (`neg_sum`=128) → rejected; 15 × 8'hF8 plus `pos_sum`=120 → accepted.
- During PENDING:
  - Writes and a second commit do not alter the shadow bank, and only one `swap_pulse` occurs.
  - An FS during CHECK does not swap; the next FS does.
- Assert `reset` in PENDING → no swap at the following FS, identity kernel, `frame_cnt`=0. Also run 256 FS events → `frame_cnt` wraps to 0.
